debouncer_multi: RTL and testbench

- Multi-channel, runtime-configurable successor to the team's single-switch debouncer.
- Each of N_CH channels has its own 2FF synchronizer, a stability counter and a per-channel pull-up/pull-down polarity.
- Adds press/release pulses, sticky event-pending flags with write-one-to-clear, and a maskable interrupt.
- Sits between board switches/buttons and the control/CSR logic that consumes clean key events.

---
 rtl/debouncer_pkg.sv | 24 ++
 rtl/debouncer_ch.sv | 71 +++++++
 rtl/debouncer_multi.sv | 71 +++++++
 tb/tb_debouncer_multi.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
package debouncer_pkg;

    localparam int MAX_CH = 32;

    // Per-channel event bundle; 'rel' is the release pulse ('release' is a keyword).
    typedef struct packed {
        logic press;
        logic rel;
        logic flip;
    } ch_evt_t;

    // A zero threshold is treated as one so a channel can never lock up.
    function automatic logic [31:0] eff_thresh(input logic [31:0] thresh);
        logic [31:0] te;
        if (thresh == 32'd0) begin
            te = 32'd1;
        end else begin
            te = thresh;
        end
        return te;
    endfunction

endpackage

// File: rtl/debouncer_ch.sv
// One debounce channel: 2FF synchronizer, stability counter, debounced level and
// polarity-corrected press/release pulses. 'flip' is the combinational update strobe.
module debouncer_ch
    import debouncer_pkg::*;
#(
    parameter int   CNT_W  = 16,
    parameter logic PULLUP = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sig,
    input  logic [CNT_W-1:0] thresh,
    output logic             debounced,
    output logic             active,
    output ch_evt_t          evt
);

    logic             s1_r;
    logic             s2_r;
    logic             deb_r;
    logic             press_r;
    logic             rel_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             deb_nxt_s;
    logic             flip_s;
    logic [CNT_W:0]   te_s;
    logic [CNT_W:0]   cnt_inc_s;

    // Stability counter next state; one bit of headroom keeps cnt+1 from wrapping.
    always_comb begin
        te_s      = (CNT_W+1)'(eff_thresh(32'(thresh)));
        cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        flip_s    = 1'b0;
        deb_nxt_s = deb_r;
        cnt_nxt_s = '0;
        if (s2_r == deb_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_inc_s >= te_s) begin
            flip_s    = 1'b1;
            deb_nxt_s = s2_r;
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
        end
    end

    // Synchronizer, counter, debounced level and registered pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_r    <= PULLUP;
            s2_r    <= PULLUP;
            deb_r   <= PULLUP;
            cnt_r   <= '0;
            press_r <= 1'b0;
            rel_r   <= 1'b0;
        end else begin
            s1_r    <= sig;
            s2_r    <= s1_r;
            deb_r   <= deb_nxt_s;
            cnt_r   <= cnt_nxt_s;
            press_r <= flip_s & (s2_r ^ PULLUP);
            rel_r   <= flip_s & ~(s2_r ^ PULLUP);
        end
    end

    assign debounced = deb_r;
    assign active    = deb_r ^ PULLUP;
    assign evt       = {press_r, rel_r, flip_s};

endmodule

// File: rtl/debouncer_multi.sv
// N_CH independent debounce channels with sticky event flags (write-one-to-clear)
// and a maskable interrupt.
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              CNT_W       = 16,
    parameter logic [N_CH-1:0] PULLUP_MASK = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_CH-1:0]  i_sig,
    input  logic [CNT_W-1:0] i_thresh,
    input  logic [N_CH-1:0]  i_evt_clr,
    input  logic [N_CH-1:0]  i_irq_en,
    output logic [N_CH-1:0]  o_debounced,
    output logic [N_CH-1:0]  o_active,
    output logic [N_CH-1:0]  o_press,
    output logic [N_CH-1:0]  o_release,
    output logic [N_CH-1:0]  o_evt_pend,
    output logic             o_irq
);

    if (N_CH < 1 || N_CH > MAX_CH) begin : g_bad_n_ch
        $error("debouncer_multi: N_CH out of range");
    end

    ch_evt_t         evt_s [N_CH];
    logic [N_CH-1:0] flip_s;
    logic [N_CH-1:0] pend_r;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        debouncer_ch #(
            .CNT_W  (CNT_W),
            .PULLUP (PULLUP_MASK[c])
        ) u_ch (
            .clk       (clk),
            .rstn      (rstn),
            .sig       (i_sig[c]),
            .thresh    (i_thresh),
            .debounced (o_debounced[c]),
            .active    (o_active[c]),
            .evt       (evt_s[c])
        );
    end

    // Gather per-channel event bundles into flat vectors.
    always_comb begin
        o_press   = '0;
        o_release = '0;
        flip_s    = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_press[c]   = evt_s[c].press;
            o_release[c] = evt_s[c].rel;
            flip_s[c]    = evt_s[c].flip;
        end
    end

    // Sticky pending flags; a new transition beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_r <= '0;
        end else begin
            pend_r <= (pend_r & ~i_evt_clr) | flip_s;
        end
    end

    assign o_evt_pend = pend_r;
    assign o_irq      = |(pend_r & i_irq_en);

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi: directed scenarios plus randomized
// stimulus compared against a run-length reference model of the debounce rules.
module tb_debouncer_multi;

    localparam int         N_CH  = 4;
    localparam int         CNT_W = 16;
    localparam logic [3:0] PU    = 4'b0100;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  i_sig;
    logic [15:0] i_thresh;
    logic [3:0]  i_evt_clr;
    logic [3:0]  i_irq_en;
    logic [3:0]  o_debounced, o_active, o_press, o_release, o_evt_pend;
    logic        o_irq;
    logic [20:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: raw-input delay line, debounced level, disagreement run length.
    logic [3:0] m_s1, m_s2, m_deb, m_press, m_rel, m_pend;
    int         m_run [4];

    debouncer_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PULLUP_MASK(PU)) dut (
        .clk(clk), .rstn(rstn), .i_sig(i_sig), .i_thresh(i_thresh),
        .i_evt_clr(i_evt_clr), .i_irq_en(i_irq_en), .o_debounced(o_debounced),
        .o_active(o_active), .o_press(o_press), .o_release(o_release),
        .o_evt_pend(o_evt_pend), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    assign dut_vec = {o_debounced, o_active, o_press, o_release, o_evt_pend, o_irq};

    function automatic logic [20:0] exp_vec();
        return {m_deb, m_deb ^ PU, m_press, m_rel, m_pend, |(m_pend & i_irq_en)};
    endfunction

    // Advance the model by the upcoming clock edge using the inputs now applied.
    task automatic model_update();
        int te;
        if (!rstn) begin
            m_s1 = PU; m_s2 = PU; m_deb = PU;
            m_press = 4'b0; m_rel = 4'b0; m_pend = 4'b0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
        end else begin
            te = (i_thresh == 16'd0) ? 1 : int'(i_thresh);
            for (int c = 0; c < 4; c++) begin
                logic fl;
                fl = (m_s2[c] != m_deb[c]) && (m_run[c] + 1 >= te);
                if (m_s2[c] == m_deb[c] || fl) m_run[c] = 0;
                else m_run[c] = m_run[c] + 1;
                m_press[c] = fl && ((m_s2[c] ^ PU[c]) == 1'b1);
                m_rel[c]   = fl && ((m_s2[c] ^ PU[c]) == 1'b0);
                m_pend[c]  = (m_pend[c] & ~i_evt_clr[c]) | fl;
                if (fl) m_deb[c] = m_s2[c];
            end
            m_s2 = m_s1;
            m_s1 = i_sig;
        end
    endtask

    task automatic step();
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; i_sig = PU; i_evt_clr = 4'b0; i_irq_en = 4'b0; i_thresh = 16'd8;
        step(); step();
        checks++;
        if (o_debounced !== 4'b0100 || o_active !== 4'b0 || o_press !== 4'b0 ||
            o_release !== 4'b0 || o_evt_pend !== 4'b0 || o_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset: got=%h want deb=4 rest=0", dut_vec);
        end
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle: got=%h want=%h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int n = 0;
        i_irq_en = 4'b0001;
        i_sig[0] = 1'b1;
        while (o_debounced[0] !== 1'b1 && n < 40) begin
            step(); n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL clean_model: got=%h want=%h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (n !== 10) begin errors++; $display("FAIL clean_latency: got=%0d want=10 edges", n); end
        checks++;
        if (o_press[0] !== 1'b1) begin errors++; $display("FAIL clean_press: got=%b want=1", o_press[0]); end
        step();
        checks++;
        if (o_press[0] !== 1'b0 || o_evt_pend[0] !== 1'b1 || o_irq !== 1'b1) begin
            errors++;
            $display("FAIL clean_after: press=%b pend=%b irq=%b want 0 1 1", o_press[0], o_evt_pend[0], o_irq);
        end
    endtask

    task automatic test_bounce();
        int highs [3] = '{3, 5, 7};
        int presses = 0;
        int early = 0;
        int n = 0;
        for (int h = 0; h < 3; h++) begin
            i_sig[1] = 1'b1;
            for (int i = 0; i < highs[h]; i++) begin
                step();
                if (o_press[1]) presses++;
                if (o_debounced[1]) early++;
            end
            i_sig[1] = 1'b0;
            repeat (2) begin step(); if (o_press[1]) presses++; if (o_debounced[1]) early++; end
        end
        checks++;
        if (early !== 0) begin errors++; $display("FAIL bounce_glitch: got %0d high cycles want 0", early); end
        i_sig[1] = 1'b1;
        while (o_debounced[1] !== 1'b1 && n < 40) begin step(); n++; if (o_press[1]) presses++; end
        checks++;
        if (n !== 10) begin errors++; $display("FAIL bounce_latency: got=%0d want=10", n); end
        repeat (5) begin step(); if (o_press[1]) presses++; end
        checks++;
        if (presses !== 1) begin errors++; $display("FAIL bounce_presses: got=%0d want=1", presses); end
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL bounce_model: got=%h want=%h", dut_vec, exp_vec()); end
    endtask

    task automatic test_pullup();
        int presses = 0;
        int rels = 0;
        checks++;
        if (o_debounced[2] !== 1'b1 || o_active[2] !== 1'b0 || o_evt_pend[2] !== 1'b0) begin
            errors++;
            $display("FAIL pullup_idle: deb=%b act=%b pend=%b want 1 0 0", o_debounced[2], o_active[2], o_evt_pend[2]);
        end
        i_sig[2] = 1'b0;
        repeat (12) begin step(); if (o_press[2]) presses++; if (o_release[2]) rels++; end
        checks++;
        if (o_active[2] !== 1'b1 || presses !== 1 || rels !== 0) begin
            errors++;
            $display("FAIL pullup_press: act=%b presses=%0d rels=%0d want 1 1 0", o_active[2], presses, rels);
        end
    endtask

    task automatic test_clear_collision();
        i_evt_clr = 4'b1111; step(); i_evt_clr = 4'b0;
        i_irq_en = 4'b1000;
        checks++;
        if (o_evt_pend !== 4'b0 || o_irq !== 1'b0) begin
            errors++; $display("FAIL clr_all: pend=%b irq=%b want 0000 0", o_evt_pend, o_irq);
        end
        i_sig[3] = 1'b1;
        repeat (9) step();
        checks++;
        if (o_debounced[3] !== 1'b0) begin errors++; $display("FAIL clr_preflip: deb=%b want 0", o_debounced[3]); end
        i_evt_clr[3] = 1'b1;
        step();
        checks++;
        if (o_debounced[3] !== 1'b1 || o_evt_pend[3] !== 1'b1 || o_irq !== 1'b1) begin
            errors++;
            $display("FAIL clr_collision: deb=%b pend=%b irq=%b want 1 1 1", o_debounced[3], o_evt_pend[3], o_irq);
        end
        step();
        i_evt_clr = 4'b0;
        checks++;
        if (o_evt_pend[3] !== 1'b0 || o_irq !== 1'b0) begin
            errors++; $display("FAIL clr_next: pend=%b irq=%b want 0 0", o_evt_pend[3], o_irq);
        end
    endtask

    task automatic test_thresh_zero();
        int n = 0;
        i_thresh = 16'd0;
        i_sig[0] = 1'b0;
        while (o_debounced[0] !== 1'b0 && n < 20) begin step(); n++; end
        checks++;
        if (n !== 3 || o_release[0] !== 1'b1) begin
            errors++; $display("FAIL thresh_zero: edges=%0d rel=%b want 3 1", n, o_release[0]);
        end
    endtask

    task automatic test_thresh_drop();
        i_thresh = 16'd16;
        i_sig[1] = 1'b0;
        repeat (7) step();
        checks++;
        if (o_debounced[1] !== 1'b1) begin errors++; $display("FAIL drop_pre: deb=%b want 1", o_debounced[1]); end
        i_thresh = 16'd4;
        step();
        checks++;
        if (o_debounced[1] !== 1'b0 || o_release[1] !== 1'b1) begin
            errors++; $display("FAIL drop_flip: deb=%b rel=%b want 0 1", o_debounced[1], o_release[1]);
        end
    endtask

    task automatic test_thresh_max();
        i_thresh = 16'hFFFF;
        i_sig[0] = 1'b1;
        repeat (65536) step();
        checks++;
        if (o_debounced[0] !== 1'b0) begin errors++; $display("FAIL max_early: deb=%b want 0", o_debounced[0]); end
        step();
        checks++;
        if (o_debounced[0] !== 1'b1 || o_press[0] !== 1'b1) begin
            errors++; $display("FAIL max_flip: deb=%b press=%b want 1 1", o_debounced[0], o_press[0]);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("FAIL max_model: got=%h want=%h", dut_vec, exp_vec()); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        i_thresh = 16'd8;
        i_sig[3] = 1'b0;
        repeat (8) step();
        checks++;
        if (o_debounced[3] !== 1'b1 || o_evt_pend[0] !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: deb3=%b pend0=%b want 1 1", o_debounced[3], o_evt_pend[0]);
        end
        rstn = 1'b0;
        step();
        checks++;
        if (o_debounced !== 4'b0100 || o_active !== 4'b0 || o_press !== 4'b0 ||
            o_release !== 4'b0 || o_evt_pend !== 4'b0 || o_irq !== 1'b0) begin
            errors++; $display("FAIL rmid_reset: got=%h want deb=4 rest=0", dut_vec);
        end
        rstn = 1'b1;
        while (o_debounced[0] !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (n !== 10 || o_press !== 4'b0101) begin
            errors++; $display("FAIL rmid_restart: edges=%0d press=%b want 10 0101", n, o_press);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) i_thresh = 16'($urandom_range(0, 5));
            if (i % 50 == 0) i_irq_en = 4'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) i_sig[c] = ~i_sig[c];
            end
            i_evt_clr = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rstn = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_model cyc=%0d: got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        rstn = 1'b1;
        i_evt_clr = 4'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_pullup();
        test_clear_collision();
        test_thresh_zero();
        test_thresh_drop();
        test_thresh_max();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
